// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter.
// Default geometry matches the datamem/progmem word port.
package mem_arb_pkg;

  localparam int AW_DEF        = 14;
  localparam int DW_DEF        = 32;
  localparam int BEW_DEF       = DW_DEF / 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// One requester's view of the shared memory port.
// Requester drives master; the arbiter takes slave.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic            req;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick with burst lock.
// Owner keeps the port until its burst expires.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       owner,
  input  logic       burst_expired,
  output logic       winner,
  output logic       any_gnt
);

  always_comb begin
    winner  = owner;
    any_gnt = |req;
    unique case (1'b1)
      (req == 2'b11): winner = burst_expired ? ~owner : owner;
      (req == 2'b10): winner = 1'b1;
      (req == 2'b01): winner = 1'b0;
      default:        winner = owner;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core bus (m0)
// and the debug/loader bus (m1), round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  mem_arb_if.slave        m0,
  mem_arb_if.slave        m1,
  output logic [DW/8-1:0] mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout
);

  localparam logic [CNT_W-1:0] CAP =
    CNT_W'(MAX_BURST - 1);

  logic             owner;
  logic             boot;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd_pend;
  logic             rd_id;
  logic             rd_zero;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    din_q;

  logic             winner;
  logic             any_req;
  logic             any;
  logic             expired;
  logic             sel_we;
  logic [DW/8-1:0]  sel_be;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_din;

  // Until the first grant, contention goes to the core bus.
  assign expired = boot | (burst_cnt >= CAP);

  rr_pick2 u_pick (
    .req           ({m1.req, m0.req}),
    .owner         (owner),
    .burst_expired (expired),
    .winner        (winner),
    .any_gnt       (any_req)
  );

  assign any = rstn & any_req;

  always_comb begin
    sel_we   = winner ? m1.we    : m0.we;
    sel_be   = winner ? m1.be    : m0.be;
    sel_addr = winner ? m1.addr  : m0.addr;
    sel_din  = winner ? m1.wdata : m0.wdata;
    m0.gnt   = any & ~winner;
    m1.gnt   = any & winner;
    mem_en   = any ? sel_be : '0;
    mem_we   = any & sel_we;
    mem_addr = any ? sel_addr : addr_q;
    mem_din  = any ? sel_din  : din_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner     <= REQ_DBG;
      boot      <= 1'b1;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_id     <= REQ_CORE;
      rd_zero   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      rd_pend <= any & ~sel_we;
      rd_id   <= winner;
      rd_zero <= (sel_be == '0);
      if (any) begin
        boot   <= 1'b0;
        addr_q <= sel_addr;
        din_q  <= sel_din;
        if (winner == owner) begin
          if (burst_cnt < CAP)
            burst_cnt <= burst_cnt + 1'b1;
        end else begin
          owner     <= winner;
          burst_cnt <= '0;
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Zero-enable reads leave mem_dout stale, so force 0.
  assign m0.rvalid = rd_pend & ~rd_id;
  assign m1.rvalid = rd_pend & rd_id;
  assign m0.rdata  = (m0.rvalid && !rd_zero)
                     ? mem_dout : '0;
  assign m1.rdata  = (m1.rvalid && !rd_zero)
                     ? mem_dout : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of a dual-port word memory (datamem/progmem port style: 14-bit word address, 4-bit byte enables, 1-bit write enable, 32-bit data, registered 1-cycle read) between two requesters.
- Requester 0 is the core data bus; requester 1 is the debug/loader bus.
- Arbitration is round-robin with a bounded burst lock, so one requester cannot starve the other.
- Sits directly in front of the memory port; the memory itself is unchanged.

Parameters:
- AW, 14, word address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_BURST, 4, max consecutive grants to one owner while the other requests; legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request; held until granted
- m0_we  in  1  1 = write, 0 = read
- m0_be  in  DW/8  byte enables
- m0_addr  in  AW  word address
- m0_wdata  in  DW  write data
- m0_gnt  out  1  transfer accepted this cycle (req & gnt)
- m0_rvalid  out  1  read data valid, one cycle after read grant
- m0_rdata  out  DW  read data, valid only with m0_rvalid
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as the m0_* ports, for requester 1
- mem_en  out  DW/8  memory byte enables (0 = no access)
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, registered, updated the cycle after an enabled read

Behaviour:
- State: owner (1 bit, last granted), burst_cnt (4 bits), rd_pend (1 bit), rd_id (1 bit), rd_zero (1 bit).
- Reset (rstn low, async): owner=1 (so req 0 wins first), burst_cnt=0, rd_pend=0, rd_id=0, rd_zero=0. While rstn low, gnt=0, mem_en=0, mem_we=0, rvalid=0, rdata=0.

Grant selection (combinational, same cycle as req):
- Only one requesting: it wins.
- Both requesting:
  - Current owner wins if burst_cnt < MAX_BURST-1.
  - Otherwise the non-owner wins.
- Neither requesting: no grant; mem_en=0, mem_we=0, mem_addr/mem_din hold previous values.

Memory drive:
- Winner's be/we/addr/wdata are driven to mem_en/mem_we/mem_addr/mem_din in the grant cycle.
- Exactly one of m0_gnt/m1_gnt is high when any req is high.

On each clock edge with a grant:
- If winner == owner: burst_cnt saturates-increments, capped at MAX_BURST-1.
- Else: owner := winner, burst_cnt := 0.

Idle cycle (no req): burst_cnt := 0, owner unchanged.

Reads:
- A granted read sets rd_pend=1 and rd_id=winner for the next cycle.
- That cycle, mN_rvalid pulses on rd_id for exactly 1 cycle, and mN_rdata = mem_dout.
- rdata is 0 on the non-selected requester and whenever rvalid is low.

Writes: no rvalid. Write completes in the grant cycle.

Zero byte enable:
- Request with be=0 is still granted and consumes a slot; mem_en=0.
- If it is a read, rvalid still pulses next cycle with rdata=0; rd_zero selects 0, because the memory does not update mem_dout.

Back-to-back:
- A read grant in cycle N and any grant in cycle N+1 are both legal. The rvalid for N appears in N+1 regardless.
- Read latency is fixed at 1 cycle; no stalls.

Reset mid-operation: a pending rvalid is dropped; no rvalid after rstn deassertion until a new read grant.

MAX_BURST=1: strict alternation whenever both request.

Decomposition:
- Package mem_arb_pkg:
  - AW/DW/BEW defaults
  - MAX_BURST default
  - requester id constants REQ_CORE=0, REQ_DBG=1
  - burst counter width constant
- Sub-module rr_pick2: combinational, inputs req[1:0], owner, burst_expired; output winner and any_gnt. Reused by later N-port arbiters.

Test Plan:
- Reset release, m0 reads addr 0x0020 (mem holds 0x00000013), be=4'hF → m0_gnt in cycle 0, m0_rvalid=1 with m0_rdata=0x00000013 in cycle 1, m1 outputs 0.
- Both requesters hold continuous reads, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0… with rvalid ids matching one cycle late.
- m1 writes 0x00000075 to 0x0040, be=4'hF; next cycle m0 reads 0x0040 → m0_rdata=0x00000075; the write produces no rvalid.
- m0 read with be=4'h0 at 0x0020 → m0_gnt=1, mem_en=0, next-cycle m0_rvalid=1 with m0_rdata=0.
- Read granted, rstn asserted low before the next edge → no rvalid after release; owner=1, so first simultaneous request goes to m0.
- MAX_BURST=1, both requesting 6 cycles → grants alternate 0,1,0,1,0,1; an idle cycle resets burst_cnt.
